// File: rtl/nisc_pkg.sv
// nisc_pkg: shared definitions for the nisc_ctrl sequencer.
//   opcode_e  - 4-bit opcode values of the instruction set
//   state_e   - sequencer states
//   OP_*/RD_*/IMM_* - bit positions of the instruction fields
package nisc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_JMP  = 4'h3,
    OP_BZ   = 4'h4,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_WB,
    S_HALTED
  } state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/nisc_ctrl.sv
// nisc_ctrl: multi-cycle load/add/branch/halt sequencer driving a register file.
// One instruction every 4 cycles: FETCH -> DECODE -> READ -> WB.
// Ports:
//   clk        system clock
//   nReset     asynchronous reset, active high
//   run        1 allows a new fetch; 0 stalls in FETCH
//   pmem_addr  program memory address (= pc)
//   pmem_data  instruction word, valid the cycle after pmem_addr
//   reg_w      register file write enable (asserted only in WB)
//   reg_addr   register file address, shared by read and write
//   reg_wdata  register file write data
//   reg_rdata  register file read data (combinational from reg_addr)
//   halted     1 once HALT has executed
//   pc_out     current program counter
// Valid/ready: there is no handshake; run is a level qualifier sampled only
// in FETCH, and pmem_data / reg_rdata are consumed at fixed cycles.
module nisc_ctrl
  import nisc_pkg::*;
#(
  parameter int n      = 8,
  parameter int Rsize  = 2,
  parameter int PCsize = 8
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              run,
  output logic [PCsize-1:0] pmem_addr,
  input  logic [15:0]       pmem_data,
  output logic              reg_w,
  output logic [Rsize-1:0]  reg_addr,
  output logic [n-1:0]      reg_wdata,
  input  logic [n-1:0]      reg_rdata,
  output logic              halted,
  output logic [PCsize-1:0] pc_out
);

  // Immediate is zero-extended or truncated to the target width.
  localparam int IW = (n < 8) ? n : 8;
  localparam int PW = (PCsize < 8) ? PCsize : 8;

  state_e            state;
  state_e            next_state;
  logic [PCsize-1:0] pc;
  logic [15:0]       ir;
  logic [n-1:0]      operand;
  opcode_e           op;
  logic [n-1:0]      imm_n;
  logic [PCsize-1:0] imm_pc;
  logic              unused_ir;

  assign op        = opcode_e'(ir[OP_MSB:OP_LSB]);
  assign pmem_addr = pc;
  assign pc_out    = pc;
  // Only some ir bits are consumed for small Rsize/n/PCsize.
  assign unused_ir = ^ir;

  always_comb begin
    imm_n          = '0;
    imm_n[IW-1:0]  = ir[IMM_LSB +: IW];
    imm_pc         = '0;
    imm_pc[PW-1:0] = ir[IMM_LSB +: PW];
  end

  // State register
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (run) next_state = S_DECODE;
      S_DECODE: next_state = S_READ;
      S_READ:   next_state = S_WB;
      S_WB:     next_state = (op == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_FETCH;
    endcase
  end

  // Datapath and registered outputs. reg_w/reg_wdata are computed at the end
  // of READ so the write strobe is a flop output that is high for WB only.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      pc        <= '0;
      ir        <= '0;
      operand   <= '0;
      reg_w     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      reg_w <= 1'b0;
      case (state)
        S_DECODE: begin
          ir       <= pmem_data;
          pc       <= pc + 1'b1;
          // Address is registered here so it is stable for all of READ.
          reg_addr <= pmem_data[RD_LSB +: Rsize];
        end
        S_READ: begin
          operand <= reg_rdata;
          if (op == OP_LDI) begin
            reg_w     <= 1'b1;
            reg_wdata <= imm_n;
          end else if (op == OP_ADDI) begin
            reg_w     <= 1'b1;
            reg_wdata <= reg_rdata + imm_n;
          end
        end
        S_WB: begin
          reg_addr <= ir[RD_LSB +: Rsize];
          // Taken branch overrides the increment done in DECODE.
          if (op == OP_JMP) pc <= imm_pc;
          if (op == OP_BZ && operand == '0) pc <= imm_pc;
          if (op == OP_HALT) halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
